apb_xfer_scheduler: RTL and testbench
=====================================

// Module: apb_xfer_scheduler
// PURPOSE
//  Sequences the APB master port of the AXI-APB bridge. Arbitrates between pending write
//  (AW+W FIFO heads) and read (AR FIFO head) requests with a bounded-burst fairness rule.
//  Runs the APB SETUP/ACCESS protocol and enforces a p_ready timeout. Returns a one-cycle
//  done pulse plus response code so the bridge can pop request FIFOs and push B/R FIFOs.
// PARAMETERS
//  AddrWidth      32  APB address width
//  DataWidth      32  APB data width
//  MaxConsec      4   max consecutive grants to one side while the other waits (1..15)
//  TimeoutCycles  16  ACCESS cycles without p_ready before forced abort; 0 = disabled
// PORTS
//  a_clk        in   1          clock
//  a_reset      in   1          synchronous reset, active-high
//  w_req        in   1          write address+data available at FIFO heads
//  w_addr       in   AddrWidth  write address (AW FIFO head)
//  w_data       in   DataWidth  write data (W FIFO head)
//  r_req        in   1          read address available
//  r_addr       in   AddrWidth  read address (AR FIFO head)
//  w_done       out  1          1-cycle pulse: write finished, pop AW/W, push B
//  r_done       out  1          1-cycle pulse: read finished, pop AR, push R
//  resp         out  2          2'b00 OKAY / 2'b10 SLVERR; valid while w_done|r_done
//  r_data_out   out  DataWidth  captured read data; valid with r_done
//  busy         out  1          high in SETUP/ACCESS/RESP
//  timeout_err  out  1          sticky: a transfer was aborted by timeout
//  err_clr      in   1          clears timeout_err
//  p_addr       out  AddrWidth  APB address
//  p_sel        out  1          APB select
//  p_enable     out  1          APB enable
//  p_write      out  1          APB direction, 1 = write
//  p_wdata      out  DataWidth  APB write data
//  p_rdata      in   DataWidth  APB read data
//  p_ready      in   1          APB ready
//  p_slverr     in   1          APB slave error
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; last-grant = read, consec = 0 (first contested grant -> write).
//  FSM: IDLE -> SETUP (any req) ; SETUP -> ACCESS (always) ; ACCESS -> RESP (p_ready | timeout);
//       RESP -> IDLE (always). Min 4 cycles/transfer; back-to-back grant on the IDLE after RESP.
//  IDLE: arbitrate on w_req/r_req; latch grant, p_addr, p_wdata (writes), p_write at IDLE->SETUP edge.
//  Arbitration: only one req -> grant it. Both -> keep last side if consec < MaxConsec, else switch.
//   Same-side grant: consec = min(consec+1, MaxConsec); other-side grant: consec = 1.
//  SETUP: p_sel=1, p_enable=0. ACCESS: p_sel=1, p_enable=1. IDLE/RESP: p_sel=p_enable=p_write=0.
//  p_addr/p_wdata hold last value outside transfers; stable SETUP through ACCESS.
//  Completion edge (ACCESS & p_ready): resp <= p_slverr ? 2'b10 : 2'b00; reads capture p_rdata.
//   p_slverr ignored when p_ready=0.
//  Timeout: counter clears on SETUP, +1 per ACCESS cycle with p_ready=0; reaching TimeoutCycles
//   ends ACCESS: resp=2'b10, r_data_out=0 on reads, timeout_err<=1. p_ready on that same cycle wins
//   (normal completion, no timeout). TimeoutCycles=0: wait forever.
//  RESP: w_done or r_done (per grant) high exactly 1 cycle; resp/r_data_out held until next completion.
//  w_req/r_req changes after grant are ignored; transfer always runs to completion.
//  err_clr and timeout set in same cycle: set wins.
//  a_reset mid-transfer: next cycle IDLE, p_sel/p_enable 0, no done pulse, arbiter state reset.
// TESTING
//  1 w_req, w_addr=0x1000, w_data=0xDEADBEEF, p_ready=1 -> cyc1 p_sel=1,p_enable=0; cyc2 p_enable=1,
//    p_write=1, p_wdata=0xDEADBEEF; cyc3 w_done=1, resp=00; cyc4 p_sel=0.
//  2 r_req, r_addr=0x2004, p_ready low 3 ACCESS cycles then high with p_rdata=0x12345678 ->
//    r_done 1 cycle after p_ready, r_data_out=0x12345678, resp=00, p_write=0 throughout.
//  3 w_req & r_req held high, MaxConsec=4 -> grant sequence W,W,W,W,R,R,R,R,W; one side dropped ->
//    other side granted every transfer.
//  4 p_ready held 0, TimeoutCycles=16 -> done after 16 ACCESS cycles, resp=10, timeout_err=1;
//    err_clr pulse -> timeout_err=0.
//  5 read with p_ready=1, p_slverr=1 -> r_done, resp=10, timeout_err stays 0.
//  6 a_reset during ACCESS of a write -> p_sel=0 next cycle, no w_done; after release, both reqs
//    -> write granted first.

Source files
------------

// File: rtl/apb_xfer_scheduler.sv
// apb_xfer_scheduler: APB master sequencer with fair write/read arbitration and ready timeout
module apb_xfer_scheduler #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int MaxConsec     = 4,
  parameter int TimeoutCycles = 16
) (
  input  logic                 a_clk,
  input  logic                 a_reset,
  input  logic                 w_req,
  input  logic [AddrWidth-1:0] w_addr,
  input  logic [DataWidth-1:0] w_data,
  input  logic                 r_req,
  input  logic [AddrWidth-1:0] r_addr,
  output logic                 w_done,
  output logic                 r_done,
  output logic [1:0]           resp,
  output logic [DataWidth-1:0] r_data_out,
  output logic                 busy,
  output logic                 timeout_err,
  input  logic                 err_clr,
  output logic [AddrWidth-1:0] p_addr,
  output logic                 p_sel,
  output logic                 p_enable,
  output logic                 p_write,
  output logic [DataWidth-1:0] p_wdata,
  input  logic [DataWidth-1:0] p_rdata,
  input  logic                 p_ready,
  input  logic                 p_slverr
);
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_RESP = 2'd3;
  localparam int TW = $clog2(TimeoutCycles + 1) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TimeoutCycles - 1);
  localparam logic [3:0] MC = 4'(MaxConsec);
  logic [1:0]    state;
  logic          grant_w, last_w, keep, pick_w, to_hit;
  logic [3:0]    consec, consec_nx;
  logic [TW-1:0] tcnt;
  // consec == 0 means no history yet, so a contested first grant goes to the write side
  always_comb begin
    keep      = consec != 4'd0 && consec < MC;
    pick_w    = w_req && (!r_req || (keep ? last_w : !last_w));
    consec_nx = pick_w != last_w ? 4'd1 : consec < MC ? consec + 4'd1 : MC;
    to_hit    = TimeoutCycles != 0 && state == S_ACCESS && !p_ready && tcnt == T_LAST;
  end
  assign p_sel    = state == S_SETUP || state == S_ACCESS;
  assign p_enable = state == S_ACCESS;
  assign p_write  = p_sel && grant_w;
  assign busy     = state != S_IDLE;
  assign w_done   = state == S_RESP && grant_w;
  assign r_done   = state == S_RESP && !grant_w;
  always_ff @(posedge a_clk)
    if (a_reset) begin
      state       <= S_IDLE;
      grant_w     <= 1'b0;
      last_w      <= 1'b0;
      consec      <= '0;
      tcnt        <= '0;
      p_addr      <= '0;
      p_wdata     <= '0;
      resp        <= '0;
      r_data_out  <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_hit || (timeout_err && !err_clr);
      case (state)
        S_IDLE:
          if (w_req || r_req) begin
            state   <= S_SETUP;
            grant_w <= pick_w;
            last_w  <= pick_w;
            consec  <= consec_nx;
            p_addr  <= pick_w ? w_addr : r_addr;
            if (pick_w) p_wdata <= w_data;
          end
        S_SETUP: begin
          state <= S_ACCESS;
          tcnt  <= '0;
        end
        S_ACCESS:
          if (p_ready) begin
            state <= S_RESP;
            resp  <= p_slverr ? 2'b10 : 2'b00;
            if (!grant_w) r_data_out <= p_rdata;
          end else if (to_hit) begin
            state <= S_RESP;
            resp  <= 2'b10;
            if (!grant_w) r_data_out <= '0;
          end else tcnt <= tcnt + TW'(1);
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_apb_xfer_scheduler.sv
// tb_apb_xfer_scheduler: vector table plus scoreboard and hand sequences for apb_xfer_scheduler
module tb_apb_xfer_scheduler;
  logic        a_clk, a_reset, w_req, r_req, err_clr;
  logic [31:0] w_addr, w_data, r_addr, p_rdata, r_data_out, p_addr, p_wdata;
  logic        w_done, r_done, busy, timeout_err, p_sel, p_enable, p_write, p_ready, p_slverr;
  logic [1:0]  resp;
  int          tests = 0, failed = 0;
  int          cfg_waits = 0;
  bit          cfg_slverr = 0;
  logic [31:0] cfg_rdata = '0;
  typedef struct {
    bit wr, rr, exp_w;
    logic [31:0] aw, dw, ar, rdata;
    int waits;
    bit slverr;
  } vec_t;
  typedef struct {
    bit w, terr;
    logic [31:0] addr, wdata, rdata;
    logic [1:0] resp;
    int acc;
  } exp_t;
  vec_t vt[16];
  exp_t sb[$];
  apb_xfer_scheduler dut (
    .a_clk(a_clk), .a_reset(a_reset), .w_req(w_req), .w_addr(w_addr), .w_data(w_data),
    .r_req(r_req), .r_addr(r_addr), .w_done(w_done), .r_done(r_done), .resp(resp),
    .r_data_out(r_data_out), .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr),
    .p_addr(p_addr), .p_sel(p_sel), .p_enable(p_enable), .p_write(p_write), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .p_ready(p_ready), .p_slverr(p_slverr)
  );
  initial begin
    a_clk = 0;
    forever #5 a_clk = ~a_clk;
  end
  // APB slave: ready after cfg_waits ACCESS cycles (never if negative); slverr/rdata are junk while not ready
  initial begin
    int acc;
    acc = 0;
    p_ready = 0;
    p_slverr = 0;
    p_rdata = '0;
    forever begin
      @(negedge a_clk);
      if (p_sel && p_enable) begin
        p_ready  = cfg_waits >= 0 && acc == cfg_waits;
        p_slverr = p_ready ? cfg_slverr : 1'b1;
        p_rdata  = p_ready ? cfg_rdata : 32'hBAD0_BAD0;
        acc++;
      end else begin
        acc = 0;
        p_ready = 0;
        p_slverr = 0;
        p_rdata = '0;
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(bit wr, bit rr, bit ew, logic [31:0] aw, logic [31:0] dw,
                              logic [31:0] ar, logic [31:0] rd, int waits, bit se);
    vec_t v;
    v.wr = wr; v.rr = rr; v.exp_w = ew; v.aw = aw; v.dw = dw; v.ar = ar;
    v.rdata = rd; v.waits = waits; v.slverr = se;
    return v;
  endfunction
  task automatic do_reset();
    a_reset = 1;
    repeat (2) @(negedge a_clk);
    a_reset = 0;
  endtask
  task automatic run_vec(input vec_t v);
    exp_t e;
    int n_acc;
    bit got;
    w_req = v.wr; r_req = v.rr; w_addr = v.aw; w_data = v.dw; r_addr = v.ar;
    cfg_waits = v.waits; cfg_slverr = v.slverr; cfg_rdata = v.rdata;
    e.w = v.exp_w;
    e.addr = v.exp_w ? v.aw : v.ar;
    e.wdata = v.dw;
    e.resp = (v.waits < 0 || v.slverr) ? 2'b10 : 2'b00;
    e.rdata = v.waits < 0 ? 32'h0 : v.rdata;
    e.terr = v.waits < 0;
    e.acc = v.waits < 0 ? 16 : v.waits + 1;
    sb.push_back(e);
    n_acc = 0;
    got = 0;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge a_clk);
      if (p_sel && !p_enable) begin
        check("setup_addr", p_addr, sb[0].addr);
        check("setup_dir", 32'(p_write), 32'(sb[0].w));
        if (sb[0].w) check("setup_wdata", p_wdata, sb[0].wdata);
      end
      if (p_sel && p_enable) n_acc++;
      if (w_done || r_done) begin
        got = 1;
        e = sb.pop_front();
        check("grant_side", {31'b0, w_done}, 32'(e.w));
        check("single_done", {31'b0, w_done & r_done}, 32'h0);
        check("resp", 32'(resp), 32'(e.resp));
        check("access_cycles", 32'(n_acc), 32'(e.acc));
        check("timeout_err", 32'(timeout_err), 32'(e.terr));
        if (!e.w) check("rdata", r_data_out, e.rdata);
      end
    end
    if (!got) begin
      check("done_seen", 32'h0, 32'h1);
      void'(sb.pop_front());
    end
  endtask
  initial begin
    bit seen;
    w_req = 0; r_req = 0; err_clr = 0; w_addr = '0; w_data = '0; r_addr = '0;
    // from reset: W,W,W,W,R,R,R,R,W under contention, then saturation and one-sided runs
    vt[0]  = mk(1, 1, 1, 32'h0000_1000, 32'hA000_0000, 32'h0000_2000, 32'h1111_0000, 0, 0);
    vt[1]  = mk(1, 1, 1, 32'h0000_1004, 32'hA000_0001, 32'h0000_2000, 32'h1111_0001, 1, 0);
    vt[2]  = mk(1, 1, 1, 32'h0000_1008, 32'hA000_0002, 32'h0000_2000, 32'h1111_0002, 2, 1);
    vt[3]  = mk(1, 1, 1, 32'h0000_100C, 32'hA000_0003, 32'h0000_2000, 32'h1111_0003, 0, 0);
    vt[4]  = mk(1, 1, 0, 32'h0000_1010, 32'hA000_0004, 32'h0000_2010, 32'h4444_4444, 0, 0);
    vt[5]  = mk(1, 1, 0, 32'h0000_1010, 32'hA000_0004, 32'h0000_2014, 32'h5555_5555, 2, 0);
    vt[6]  = mk(1, 1, 0, 32'h0000_1010, 32'hA000_0004, 32'h0000_2018, 32'h6666_6666, 0, 1);
    vt[7]  = mk(1, 1, 0, 32'h0000_1010, 32'hA000_0004, 32'h0000_201C, 32'h7777_7777, 15, 0);
    vt[8]  = mk(1, 1, 1, 32'h0000_1020, 32'hA000_0008, 32'h0000_2020, 32'h8888_8888, 0, 0);
    vt[9]  = mk(1, 0, 1, 32'h0000_1024, 32'hA000_0009, 32'h0000_2024, 32'h9999_9999, 1, 0);
    vt[10] = mk(1, 0, 1, 32'h0000_1028, 32'hA000_000A, 32'h0000_2028, 32'h0, 0, 0);
    vt[11] = mk(1, 0, 1, 32'h0000_102C, 32'hA000_000B, 32'h0000_202C, 32'h0, 0, 1);
    vt[12] = mk(1, 0, 1, 32'h0000_1030, 32'hA000_000C, 32'h0000_2030, 32'h0, 0, 0);
    vt[13] = mk(1, 1, 0, 32'h0000_1034, 32'hA000_000D, 32'h0000_2034, 32'hCAFE_F00D, 0, 0);
    vt[14] = mk(0, 1, 0, 32'h0000_1038, 32'hA000_000E, 32'h0000_2004, 32'h1234_5678, 3, 0);
    vt[15] = mk(0, 1, 0, 32'h0000_103C, 32'hA000_000F, 32'h0000_2040, 32'hFFFF_FFFF, -1, 0);
    a_reset = 1;
    repeat (3) @(negedge a_clk);
    check("rst_p_sel", {31'b0, p_sel}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {30'b0, w_done, r_done}, 32'h0);
    check("rst_resp", 32'(resp), 32'h0);
    check("rst_rdata", r_data_out, 32'h0);
    check("rst_p_addr", p_addr, 32'h0);
    check("rst_terr", {31'b0, timeout_err}, 32'h0);
    a_reset = 0;
    // single write, cycle by cycle; w_req drops right after the grant
    w_req = 1; w_addr = 32'h0000_1000; w_data = 32'hDEAD_BEEF; cfg_waits = 0; cfg_slverr = 0;
    @(negedge a_clk);
    check("t1_setup", {30'b0, p_sel, p_enable}, 32'h2);
    w_req = 0;
    @(negedge a_clk);
    check("t1_access", {29'b0, p_sel, p_enable, p_write}, 32'h7);
    check("t1_wdata", p_wdata, 32'hDEAD_BEEF);
    check("t1_addr", p_addr, 32'h0000_1000);
    @(negedge a_clk);
    check("t1_done", {30'b0, w_done, r_done}, 32'h2);
    check("t1_resp", 32'(resp), 32'h0);
    check("t1_resp_psel", {29'b0, p_sel, busy, p_write}, 32'h2);
    @(negedge a_clk);
    check("t1_idle", {29'b0, p_sel, w_done, busy}, 32'h0);
    do_reset();
    foreach (vt[i]) run_vec(vt[i]);
    w_req = 0; r_req = 0;
    @(negedge a_clk);
    check("terr_sticky", {31'b0, timeout_err}, 32'h1);
    err_clr = 1;
    @(negedge a_clk);
    err_clr = 0;
    check("terr_cleared", {31'b0, timeout_err}, 32'h0);
    // reset in the middle of a stalled write aborts it with no done pulse
    w_req = 1; w_addr = 32'h0000_3000; w_data = 32'h0BAD_F00D; cfg_waits = -1;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge a_clk);
      seen = p_sel && p_enable;
    end
    check("t6_access_seen", {31'b0, seen}, 32'h1);
    @(negedge a_clk);
    a_reset = 1; r_req = 1; r_addr = 32'h0000_4000;
    @(negedge a_clk);
    check("t6_abort", {28'b0, p_sel, p_enable, w_done, r_done}, 32'h0);
    a_reset = 0; cfg_waits = 0; w_addr = 32'h0000_3010;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge a_clk);
      if (w_done || r_done) check("t6_no_done", 32'h1, 32'h0);
      seen = p_sel && !p_enable;
    end
    check("t6_setup_seen", {31'b0, seen}, 32'h1);
    check("t6_write_first", {31'b0, p_write}, 32'h1);
    check("t6_addr", p_addr, 32'h0000_3010);
    w_req = 0; r_req = 0;
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge a_clk);
      seen = w_done || r_done;
    end
    check("t6_wdone", {30'b0, w_done, r_done}, 32'h2);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
